miner_job_ctrl: RTL and testbench
=================================

MINER_JOB_CTRL -- requirements
Module: miner_job_ctrl

Interface
REQ-001 NUM_CORES, 4, number of attached hashing cores, legal 1..16.
REQ-002 FIFO_DEPTH, 8, result FIFO entries, power of two, >=2.
REQ-003 wb_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 wb_rst  input  1  asynchronous, active-high reset.
REQ-005 wb_cycle  input  1  Wishbone classic cycle.
REQ-006 wb_strobe  input  1  Wishbone strobe.
REQ-007 wb_we  input  1  write enable.
REQ-008 wb_sel  input  4  byte lane enables.
REQ-009 wb_addr  input  8  byte address.
REQ-010 wb_wdata  input  32  write data.
REQ-011 wb_ack  output  1  normal termination.
REQ-012 wb_err  output  1  error termination.
REQ-013 wb_rdata  output  32  read data.
REQ-014 core_start  output  NUM_CORES  one-cycle start pulse per core.
REQ-015 core_abort  output  NUM_CORES  one-cycle abort pulse per core.
REQ-016 core_nonce  output  32*NUM_CORES  first nonce of core i in bits [32i+31:32i].
REQ-017 core_nonce_end  output  32  last nonce of job, shared.
REQ-018 core_stride  output  8  constant NUM_CORES.
REQ-019 core_done  input  NUM_CORES  level, core finished its slice.
REQ-020 found_valid  input  NUM_CORES  core i offers a found nonce.
REQ-021 found_nonce  input  32*NUM_CORES  found nonce of core i.
REQ-022 found_ready  output  NUM_CORES  result accepted this cycle.
REQ-023 irq  output  1  registered interrupt.

Function
REQ-024 Request = wb_cycle & wb_strobe & !wb_ack & !wb_err; exactly one of wb_ack/wb_err pulses high for one cycle, the cycle after the request.
REQ-025 wb_err for addr[1:0]!=0 or unmapped address; such writes have no effect, wb_rdata=0.
REQ-026 Map: 0x00 CTRL (W: bit0 START, bit1 ABORT; reads 0); 0x04 STATUS (R: bit0 BUSY, [15:8] FIFO count, [23:16] NUM_CORES); 0x08 NONCE_START RW; 0x0C NONCE_END RW; 0x10 RESULT R; 0x14 IRQ_EN RW [1:0]; 0x18 IRQ_STAT (bit0 FOUND, bit1 DONE).
REQ-027 RW registers update per byte lane by wb_sel; CTRL and IRQ_STAT act only when wb_sel[0]=1.
REQ-028 FSM states IDLE, RUN; BUSY=1 in RUN only.
REQ-029 START in IDLE with NONCE_END>=NONCE_START: latch core_nonce[i]=NONCE_START+i (mod 2^32) and core_nonce_end=NONCE_END, pulse all core_start bits the cycle after ack, enter RUN.
REQ-030 START in IDLE with NONCE_END<NONCE_START: no core_start, set DONE, remain IDLE.
REQ-031 START in RUN ignored; NONCE_START/NONCE_END writes in RUN update registers but not latched core outputs.
REQ-032 RUN->IDLE when all core_done bits high, evaluated from the 2nd cycle after core_start onward; sets DONE.
REQ-033 ABORT in RUN: pulse all core_abort bits for one cycle, enter IDLE, DONE not set; ABORT in IDLE no effect; START and ABORT in same write: ABORT wins, no start.
REQ-034 Result arbitration: fixed priority, lowest index with found_valid wins; found_ready one-hot to winner when FIFO not full, all zero when full (no loss); accepted nonce pushed same edge.
REQ-035 Results accepted in IDLE and RUN.
REQ-036 RESULT read, FIFO non-empty: returns head, pops; empty: returns 0xFFFF_FFFF, no pop.
REQ-037 Simultaneous push and pop: both occur, count unchanged; push to full blocked even if popping same cycle.
REQ-038 FOUND = FIFO non-empty (level, write ignored); DONE sticky, cleared by write 1 to bit1.
REQ-039 irq = registered |(IRQ_EN & IRQ_STAT), one-cycle lag.

Reset
REQ-040 On wb_rst: state IDLE, FIFO empty, all registers 0, all outputs 0 except core_stride=NUM_CORES; mid-job reset abandons job with no core_abort pulse.

Verification
REQ-041 NONCE_START=0x100, NONCE_END=0x1FF, START -> core_start=4'b1111 one cycle, core_nonce={0x103,0x102,0x101,0x100}, BUSY=1.
REQ-042 In RUN, raise core_done per core one by one -> IDLE and DONE only after 4th; IRQ_EN=2 -> irq next cycle; W1C bit1 -> irq drops.
REQ-043 found_valid=4'b0110 held -> core1 accepted first, core2 next cycle; RESULT reads 2 nonces in order then 0xFFFF_FFFF.
REQ-044 Push 9 results with FIFO_DEPTH=8 -> 9th stalled, found_ready=0 until one RESULT read, then accepted.
REQ-045 NONCE_END<NONCE_START START -> no core_start, DONE=1; START+ABORT during RUN -> core_abort pulse, IDLE, DONE unchanged.
REQ-046 Read 0x1C and 0x02 -> wb_err pulse, no ack; wb_rst mid-RUN -> all outputs 0, STATUS reads 0x0004_0000.

Source files
------------

// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl: Wishbone-controlled job dispatcher for a bank of nonce-search cores.
//
// Ports:
//   wb_clk, wb_rst                 clock, asynchronous active-high reset
//   wb_cycle/strobe/we/sel/addr/wdata  Wishbone classic slave request
//   wb_ack, wb_err, wb_rdata       registered termination one cycle after the request
//   core_start, core_abort         one-cycle pulses to every core
//   core_nonce, core_nonce_end     per-core first nonce, shared last nonce (latched at START)
//   core_stride                    constant NUM_CORES
//   core_done                      level, core finished its slice
//   found_valid/found_nonce/found_ready  result offer/accept handshake per core
//   irq                            registered interrupt
module miner_job_ctrl #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic                    wb_cycle,
    input  logic                    wb_strobe,
    input  logic                    wb_we,
    input  logic [3:0]              wb_sel,
    input  logic [7:0]              wb_addr,
    input  logic [31:0]             wb_wdata,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic [31:0]             wb_rdata,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES-1:0]    core_abort,
    output logic [32*NUM_CORES-1:0] core_nonce,
    output logic [31:0]             core_nonce_end,
    output logic [7:0]              core_stride,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    found_valid,
    input  logic [32*NUM_CORES-1:0] found_nonce,
    output logic [NUM_CORES-1:0]    found_ready,
    output logic                    irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [7:0] AddrCtrl    = 8'h00;
    localparam logic [7:0] AddrStatus  = 8'h04;
    localparam logic [7:0] AddrNStart  = 8'h08;
    localparam logic [7:0] AddrNEnd    = 8'h0C;
    localparam logic [7:0] AddrResult  = 8'h10;
    localparam logic [7:0] AddrIrqEn   = 8'h14;
    localparam logic [7:0] AddrIrqStat = 8'h18;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                    r_state;
    state_e                    w_state_d;
    logic                      r_ack;
    logic                      r_err;
    logic [31:0]               r_rdata;
    logic [31:0]               r_nonce_start;
    logic [31:0]               r_nonce_end;
    logic [1:0]                r_irq_en;
    logic                      r_done;
    logic                      r_irq;
    logic [1:0]                r_settle;
    logic [NUM_CORES-1:0]      r_core_start;
    logic [NUM_CORES-1:0]      r_core_abort;
    logic [32*NUM_CORES-1:0]   r_core_nonce;
    logic [31:0]               r_core_nonce_end;
    logic [31:0]               r_fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;

    logic                      w_req;
    logic                      w_bad_addr;
    logic                      w_wr;
    logic                      w_rd;
    logic                      w_ctrl_wr;
    logic                      w_cmd_start;
    logic                      w_cmd_abort;
    logic                      w_job_start;
    logic                      w_job_empty;
    logic                      w_job_abort;
    logic                      w_job_done;
    logic                      w_done_clr;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_any;
    logic [NUM_CORES-1:0]      w_grant;
    logic [31:0]               w_win_nonce;
    logic [31:0]               w_rdata_mux;
    logic [7:0]                w_count8;

    // Bus decode
    assign w_req      = wb_cycle & wb_strobe & ~wb_ack & ~wb_err;
    assign w_bad_addr = (wb_addr[1:0] != 2'b00) || (wb_addr > AddrIrqStat);
    assign w_wr       = w_req & wb_we & ~w_bad_addr;
    assign w_rd       = w_req & ~wb_we & ~w_bad_addr;
    assign w_ctrl_wr  = w_wr & (wb_addr == AddrCtrl) & wb_sel[0];
    assign w_cmd_abort = w_ctrl_wr & wb_wdata[1];
    // ABORT in the same write suppresses START.
    assign w_cmd_start = w_ctrl_wr & wb_wdata[0] & ~wb_wdata[1];
    assign w_done_clr  = w_wr & (wb_addr == AddrIrqStat) & wb_sel[0] & wb_wdata[1];

    assign w_job_start = w_cmd_start & (r_state == StIdle) & (r_nonce_end >= r_nonce_start);
    assign w_job_empty = w_cmd_start & (r_state == StIdle) & (r_nonce_end < r_nonce_start);
    assign w_job_abort = w_cmd_abort & (r_state == StRun);
    // core_done is ignored until r_settle drains, so stale done levels from the
    // previous job cannot end the new one.
    assign w_job_done  = (r_state == StRun) & (r_settle == 2'd0) & (&core_done) & ~w_job_abort;

    // FSM
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_job_start) w_state_d = StRun;
            StRun:   if (w_job_abort || w_job_done) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    // Fixed-priority arbiter: lowest index wins
    always_comb begin
        w_grant     = '0;
        w_win_nonce = '0;
        w_any       = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (found_valid[i] && !w_any) begin
                w_any       = 1'b1;
                w_grant[i]  = 1'b1;
                w_win_nonce = found_nonce[32*i +: 32];
            end
        end
    end

    assign w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = w_any & ~w_fifo_full;
    assign w_pop        = w_rd & (wb_addr == AddrResult) & ~w_fifo_empty;
    assign w_count8     = 8'(r_count);

    // Read mux
    always_comb begin
        w_rdata_mux = '0;
        unique case (wb_addr)
            AddrStatus:  w_rdata_mux = {8'h00, 8'(NUM_CORES), w_count8, 7'h00, r_state == StRun};
            AddrNStart:  w_rdata_mux = r_nonce_start;
            AddrNEnd:    w_rdata_mux = r_nonce_end;
            AddrResult:  w_rdata_mux = w_fifo_empty ? 32'hFFFF_FFFF : r_fifo_mem[r_rd_ptr];
            AddrIrqEn:   w_rdata_mux = {30'h0, r_irq_en};
            AddrIrqStat: w_rdata_mux = {30'h0, r_done, ~w_fifo_empty};
            default:     w_rdata_mux = '0;
        endcase
    end

    // Registers, job latches, FIFO
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_ack            <= 1'b0;
            r_err            <= 1'b0;
            r_rdata          <= '0;
            r_nonce_start    <= '0;
            r_nonce_end      <= '0;
            r_irq_en         <= '0;
            r_done           <= 1'b0;
            r_irq            <= 1'b0;
            r_settle         <= '0;
            r_core_start     <= '0;
            r_core_abort     <= '0;
            r_core_nonce     <= '0;
            r_core_nonce_end <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) r_fifo_mem[k] <= '0;
        end else begin
            r_ack   <= w_req & ~w_bad_addr;
            r_err   <= w_req & w_bad_addr;
            r_rdata <= w_rd ? w_rdata_mux : 32'h0;

            if (w_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_sel[b]) begin
                        if (wb_addr == AddrNStart) r_nonce_start[8*b +: 8] <= wb_wdata[8*b +: 8];
                        if (wb_addr == AddrNEnd)   r_nonce_end[8*b +: 8]   <= wb_wdata[8*b +: 8];
                    end
                end
                if (wb_addr == AddrIrqEn && wb_sel[0]) r_irq_en <= wb_wdata[1:0];
            end

            // Set beats clear when both happen in one cycle.
            if (w_job_done || w_job_empty) r_done <= 1'b1;
            else if (w_done_clr)           r_done <= 1'b0;

            r_irq <= |(r_irq_en & {r_done, ~w_fifo_empty});

            // Start pulse goes out the cycle after ack; r_settle then keeps
            // counting down to open the done-evaluation window.
            if (w_job_start) begin
                r_settle         <= 2'd3;
                r_core_nonce_end <= r_nonce_end;
                for (int i = 0; i < NUM_CORES; i++) begin
                    r_core_nonce[32*i +: 32] <= r_nonce_start + 32'(i);
                end
            end else if (r_settle != 2'd0) begin
                r_settle <= r_settle - 2'd1;
            end
            r_core_start <= (r_settle == 2'd3) ? '1 : '0;
            r_core_abort <= w_job_abort ? '1 : '0;

            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= w_win_nonce;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    assign wb_ack         = r_ack;
    assign wb_err         = r_err;
    assign wb_rdata       = r_rdata;
    assign core_start     = r_core_start;
    assign core_abort     = r_core_abort;
    assign core_nonce     = r_core_nonce;
    assign core_nonce_end = r_core_nonce_end;
    assign core_stride    = 8'(NUM_CORES);
    assign found_ready    = (w_push && !wb_rst) ? w_grant : '0;
    assign irq            = r_irq;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// tb_miner_job_ctrl: scoreboard bench for miner_job_ctrl (NUM_CORES=4, FIFO_DEPTH=8).
// Expected RESULT values are queued when a core offer is driven and popped on RESULT reads.
module tb_miner_job_ctrl;

    localparam int NC = 4;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_NSTART = 8'h08;
    localparam logic [7:0] A_NEND   = 8'h0C;
    localparam logic [7:0] A_RESULT = 8'h10;
    localparam logic [7:0] A_IRQEN  = 8'h14;
    localparam logic [7:0] A_IRQST  = 8'h18;

    logic              wb_clk = 1'b0;
    logic              wb_rst;
    logic              wb_cycle, wb_strobe, wb_we;
    logic [3:0]        wb_sel;
    logic [7:0]        wb_addr;
    logic [31:0]       wb_wdata;
    logic              wb_ack, wb_err;
    logic [31:0]       wb_rdata;
    logic [NC-1:0]     core_start, core_abort, core_done, found_valid, found_ready;
    logic [32*NC-1:0]  core_nonce, found_nonce;
    logic [31:0]       core_nonce_end;
    logic [7:0]        core_stride;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q [$];

    miner_job_ctrl #(.NUM_CORES(NC), .FIFO_DEPTH(8)) dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .wb_cycle       (wb_cycle),
        .wb_strobe      (wb_strobe),
        .wb_we          (wb_we),
        .wb_sel         (wb_sel),
        .wb_addr        (wb_addr),
        .wb_wdata       (wb_wdata),
        .wb_ack         (wb_ack),
        .wb_err         (wb_err),
        .wb_rdata       (wb_rdata),
        .core_start     (core_start),
        .core_abort     (core_abort),
        .core_nonce     (core_nonce),
        .core_nonce_end (core_nonce_end),
        .core_stride    (core_stride),
        .core_done      (core_done),
        .found_valid    (found_valid),
        .found_nonce    (found_nonce),
        .found_ready    (found_ready),
        .irq            (irq)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge wb_clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that terminates the cycle.
    task automatic wb_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output logic ak, output logic er);
        if (wb_ack || wb_err) cyc(1);
        wb_cycle = 1'b1; wb_strobe = 1'b1; wb_we = we;
        wb_addr = a; wb_wdata = d; wb_sel = s;
        cyc(1);
        rd = wb_rdata; ak = wb_ack; er = wb_err;
        wb_cycle = 1'b0; wb_strobe = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic ak, er;
        wb_xfer(1'b1, a, d, s, rd, ak, er);
        check_eq("wr_ack", {31'b0, ak}, 32'd1);
    endtask

    task automatic wb_rd(input logic [7:0] a, output logic [31:0] d);
        logic ak, er;
        wb_xfer(1'b0, a, 32'h0, 4'hF, d, ak, er);
        check_eq("rd_ack", {31'b0, ak}, 32'd1);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_rd(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic read_result();
        logic [31:0] d;
        wb_rd(A_RESULT, d);
        if (exp_q.size() == 0) check_eq("result_empty", d, 32'hFFFF_FFFF);
        else                   check_eq("result", d, exp_q.pop_front());
    endtask

    // Core model offers one nonce, drops valid once accepted.
    task automatic offer(input int core, input logic [31:0] n);
        found_valid = '0;
        found_valid[core] = 1'b1;
        found_nonce[32*core +: 32] = n;
        #1;
        check_eq("offer_ready", {28'b0, found_ready}, 32'(1 << core));
        exp_q.push_back(n);
        cyc(1);
        found_valid = '0;
    endtask

    task automatic check_start_pulse(input logic [31:0] base, input logic [31:0] nend);
        check_eq("start_early", {28'b0, core_start}, 32'h0);
        cyc(1);
        check_eq("start_pulse", {28'b0, core_start}, 32'hF);
        for (int i = 0; i < NC; i++) check_eq("core_nonce", core_nonce[32*i +: 32], base + 32'(i));
        check_eq("nonce_end", core_nonce_end, nend);
        cyc(1);
        check_eq("start_gone", {28'b0, core_start}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic ak, er;

        wb_rst = 1'b1; wb_cycle = 1'b0; wb_strobe = 1'b0; wb_we = 1'b0;
        wb_sel = '0; wb_addr = '0; wb_wdata = '0;
        core_done = '0; found_valid = '0; found_nonce = '0;
        cyc(2);
        check_eq("rst_ack", {30'b0, wb_ack, wb_err}, 32'h0);
        check_eq("rst_start", {24'b0, core_start, core_abort}, 32'h0);
        check_eq("rst_nonce0", core_nonce[31:0], 32'h0);
        check_eq("rst_stride", {24'b0, core_stride}, 32'd4);
        check_eq("rst_irq", {31'b0, irq}, 32'h0);
        wb_rst = 1'b0;
        cyc(1);
        rd_check("status_rst", A_STATUS, 32'h0004_0000);

        // Byte lanes
        wb_wr(A_NSTART, 32'h1111_1111, 4'hF);
        wb_wr(A_NSTART, 32'h0000_0100, 4'b0011);
        rd_check("lane_lo", A_NSTART, 32'h1111_0100);
        wb_wr(A_NSTART, 32'h0000_0100, 4'b1100);
        rd_check("lane_hi", A_NSTART, 32'h0000_0100);
        wb_wr(A_NEND, 32'h0000_01FF, 4'hF);

        // Job start
        wb_wr(A_CTRL, 32'h1, 4'h1);
        check_start_pulse(32'h100, 32'h1FF);
        rd_check("status_busy", A_STATUS, 32'h0004_0001);

        // START in RUN ignored; NONCE_START write leaves latched outputs
        wb_wr(A_CTRL, 32'h1, 4'h1);
        cyc(1);
        check_eq("start_in_run", {28'b0, core_start}, 32'h0);
        wb_wr(A_NSTART, 32'h0000_0050, 4'hF);
        check_eq("latched_nonce", core_nonce[31:0], 32'h100);
        wb_wr(A_NSTART, 32'h0000_0100, 4'hF);

        // Done one core at a time
        for (int i = 0; i < NC - 1; i++) begin
            core_done[i] = 1'b1;
            cyc(1);
        end
        rd_check("busy_3done", A_STATUS, 32'h0004_0001);
        rd_check("irqst_3done", A_IRQST, 32'h0);
        wb_wr(A_IRQEN, 32'h2, 4'hF);
        core_done[NC-1] = 1'b1;
        cyc(1);
        check_eq("irq_lag", {31'b0, irq}, 32'h0);
        cyc(1);
        check_eq("irq_done", {31'b0, irq}, 32'h1);
        core_done = '0;
        rd_check("status_done", A_STATUS, 32'h0004_0000);
        rd_check("irqst_done", A_IRQST, 32'h2);
        wb_wr(A_IRQST, 32'h2, 4'h1);
        cyc(1);
        check_eq("irq_cleared", {31'b0, irq}, 32'h0);

        // Two simultaneous offers
        found_nonce[63:32] = 32'hAAAA_0001;
        found_nonce[95:64] = 32'hBBBB_0002;
        found_valid = 4'b0110;
        #1;
        check_eq("arb_first", {28'b0, found_ready}, 32'h2);
        exp_q.push_back(32'hAAAA_0001);
        cyc(1);
        found_valid = 4'b0100;
        #1;
        check_eq("arb_second", {28'b0, found_ready}, 32'h4);
        exp_q.push_back(32'hBBBB_0002);
        cyc(1);
        found_valid = '0;
        rd_check("status_cnt2", A_STATUS, 32'h0004_0200);
        rd_check("irqst_found", A_IRQST, 32'h1);
        read_result();
        read_result();
        read_result();

        // Fill FIFO, 9th offer stalls until a pop
        for (int k = 0; k < 8; k++) offer(0, 32'h5000_0000 + 32'(k));
        rd_check("status_full", A_STATUS, 32'h0004_0800);
        found_nonce[127:96] = 32'h9999_0009;
        found_valid = 4'b1000;
        #1;
        check_eq("full_stall", {28'b0, found_ready}, 32'h0);
        cyc(2);
        check_eq("full_stall2", {28'b0, found_ready}, 32'h0);
        read_result();
        check_eq("after_pop", {28'b0, found_ready}, 32'h8);
        exp_q.push_back(32'h9999_0009);
        cyc(1);
        found_valid = '0;
        rd_check("status_full2", A_STATUS, 32'h0004_0800);
        for (int k = 0; k < 9; k++) read_result();

        // Empty range
        wb_wr(A_NSTART, 32'h10, 4'hF);
        wb_wr(A_NEND, 32'h5, 4'hF);
        wb_wr(A_CTRL, 32'h1, 4'h1);
        check_eq("empty_nostart", {28'b0, core_start}, 32'h0);
        cyc(1);
        check_eq("empty_nostart2", {28'b0, core_start}, 32'h0);
        rd_check("empty_done", A_IRQST, 32'h2);
        rd_check("empty_idle", A_STATUS, 32'h0004_0000);
        wb_wr(A_IRQST, 32'h2, 4'h1);

        // Abort with START+ABORT during RUN
        wb_wr(A_NSTART, 32'h100, 4'hF);
        wb_wr(A_NEND, 32'h1FF, 4'hF);
        wb_wr(A_CTRL, 32'h1, 4'h1);
        check_start_pulse(32'h100, 32'h1FF);
        wb_wr(A_CTRL, 32'h3, 4'h1);
        check_eq("abort_pulse", {28'b0, core_abort}, 32'hF);
        cyc(1);
        check_eq("abort_gone", {24'b0, core_start, core_abort}, 32'h0);
        rd_check("abort_idle", A_STATUS, 32'h0004_0000);
        rd_check("abort_nodone", A_IRQST, 32'h0);

        // Error terminations
        wb_xfer(1'b0, 8'h1C, 32'h0, 4'hF, rd, ak, er);
        check_eq("err_1c", {30'b0, ak, er}, 32'h1);
        check_eq("err_1c_data", rd, 32'h0);
        wb_xfer(1'b0, 8'h02, 32'h0, 4'hF, rd, ak, er);
        check_eq("err_02", {30'b0, ak, er}, 32'h1);
        wb_xfer(1'b1, 8'h0A, 32'hDEAD_BEEF, 4'hF, rd, ak, er);
        check_eq("err_wr", {30'b0, ak, er}, 32'h1);
        rd_check("err_wr_noeffect", A_NSTART, 32'h100);

        // Reset mid-RUN
        wb_wr(A_CTRL, 32'h1, 4'h1);
        check_start_pulse(32'h100, 32'h1FF);
        wb_rst = 1'b1;
        #1;
        check_eq("mid_rst_nonce", core_nonce[31:0], 32'h0);
        check_eq("mid_rst_end", core_nonce_end, 32'h0);
        check_eq("mid_rst_pulses", {24'b0, core_start, core_abort}, 32'h0);
        check_eq("mid_rst_bus", {30'b0, wb_ack, wb_err}, 32'h0);
        cyc(1);
        check_eq("mid_rst_abort", {28'b0, core_abort}, 32'h0);
        wb_rst = 1'b0;
        cyc(1);
        rd_check("status_after_rst", A_STATUS, 32'h0004_0000);
        rd_check("nstart_after_rst", A_NSTART, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
